// File: rtl/axil_rr_arbiter_if.sv
// AXI4-Lite signal bundle used for both requester ports and the shared downstream port.
interface axil_rr_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [2:0]              awprot;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [2:0]              arprot;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid,    input wready,
        input  bresp, bvalid,           output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid,    output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid,    output wready,
        output bresp, bvalid,           input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid,    input rready
    );
endinterface

// File: rtl/axil_rr_arbiter.sv
// Two-master AXI4-Lite arbiter: whole-transaction round-robin over {s1r, s1w, s0r, s0w}.
// Optional AXIL_ARB_DECERR_EN: addresses >= ADDR_LIMIT are answered locally with DECERR.
module axil_rr_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = 'h10
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    axil_rr_arbiter_if.slave  s0,
    axil_rr_arbiter_if.slave  s1,
    axil_rr_arbiter_if.master m,
    output logic              busy,
    output logic [1:0]        grant_src
);
    localparam int SW = DATA_WIDTH / 8;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] awaddr;
        logic [2:0]            awprot;
        logic                  awvalid;
        logic [DATA_WIDTH-1:0] wdata;
        logic [SW-1:0]         wstrb;
        logic                  wvalid;
        logic                  bready;
        logic [ADDR_WIDTH-1:0] araddr;
        logic [2:0]            arprot;
        logic                  arvalid;
        logic                  rready;
    } req_t;

    typedef struct packed {
        logic                  awready;
        logic                  wready;
        logic [1:0]            bresp;
        logic                  bvalid;
        logic                  arready;
        logic [DATA_WIDTH-1:0] rdata;
        logic [1:0]            rresp;
        logic                  rvalid;
    } rsp_t;

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] rr, gsrc, pick;
    logic       aw_done, w_done, aw_done_nxt, w_done_nxt;
    logic       oob_q, oob_nxt, grant;
    logic [3:0] req;
    req_t [1:0] sreq;
    rsp_t [1:0] srsp;
    req_t       sel, mreq;
    rsp_t       g;

    assign sreq[0] = '{awaddr: s0.awaddr, awprot: s0.awprot, awvalid: s0.awvalid,
                       wdata: s0.wdata, wstrb: s0.wstrb, wvalid: s0.wvalid, bready: s0.bready,
                       araddr: s0.araddr, arprot: s0.arprot, arvalid: s0.arvalid,
                       rready: s0.rready};
    assign sreq[1] = '{awaddr: s1.awaddr, awprot: s1.awprot, awvalid: s1.awvalid,
                       wdata: s1.wdata, wstrb: s1.wstrb, wvalid: s1.wvalid, bready: s1.bready,
                       araddr: s1.araddr, arprot: s1.arprot, arvalid: s1.arvalid,
                       rready: s1.rready};

    // Bit index doubles as the grant code {port, is_read}.
    assign req = {sreq[1].arvalid, sreq[1].awvalid, sreq[0].arvalid, sreq[0].awvalid};
    assign sel = sreq[gsrc[1]];

    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
        logic [1:0] idx;
        rr_pick = ptr;
        // Walk from farthest to nearest so the nearest asserted source wins.
        for (int i = 3; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign pick = rr_pick(req, rr);

`ifdef AXIL_ARB_DECERR_EN
    assign oob_nxt = (pick[0] ? sreq[pick[1]].araddr : sreq[pick[1]].awaddr) >= ADDR_LIMIT;
`else
    logic unused_limit;
    assign oob_nxt      = 1'b0;
    assign unused_limit = |ADDR_LIMIT;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state   <= IDLE;
            rr      <= 2'd0;
            gsrc    <= 2'd0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            aw_done <= aw_done_nxt;
            w_done  <= w_done_nxt;
            if (grant) begin
                gsrc  <= pick;
                rr    <= pick + 2'd1;
                oob_q <= oob_nxt;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        aw_done_nxt = aw_done;
        w_done_nxt  = w_done;
        grant       = 1'b0;
        mreq        = '0;
        g           = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant     = 1'b1;
                    state_nxt = pick[0] ? RD_REQ : WR_REQ;
                end
            end
            WR_REQ: begin
                if (!oob_q) begin
                    mreq.awaddr  = sel.awaddr;
                    mreq.awprot  = sel.awprot;
                    mreq.awvalid = sel.awvalid & ~aw_done;
                    mreq.wdata   = sel.wdata;
                    mreq.wstrb   = sel.wstrb;
                    mreq.wvalid  = sel.wvalid & ~w_done;
                    g.awready    = m.awready & ~aw_done;
                    g.wready     = m.wready & ~w_done;
                end else begin
                    g.awready = ~aw_done;
                    g.wready  = ~w_done;
                end
                if (sel.awvalid & g.awready) aw_done_nxt = 1'b1;
                if (sel.wvalid & g.wready)   w_done_nxt  = 1'b1;
                if (aw_done_nxt & w_done_nxt) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (!oob_q) begin
                    mreq.bready = sel.bready;
                    g.bvalid    = m.bvalid;
                    g.bresp     = m.bresp;
                end else begin
                    g.bvalid = 1'b1;
                    g.bresp  = 2'b11;
                end
                if (g.bvalid & sel.bready) begin
                    state_nxt   = IDLE;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            RD_REQ: begin
                if (!oob_q) begin
                    mreq.araddr  = sel.araddr;
                    mreq.arprot  = sel.arprot;
                    mreq.arvalid = sel.arvalid;
                    g.arready    = m.arready;
                end else begin
                    g.arready = 1'b1;
                end
                if (sel.arvalid & g.arready) state_nxt = RD_RESP;
            end
            RD_RESP: begin
                if (!oob_q) begin
                    mreq.rready = sel.rready;
                    g.rvalid    = m.rvalid;
                    g.rdata     = m.rdata;
                    g.rresp     = m.rresp;
                end else begin
                    g.rvalid = 1'b1;
                    g.rresp  = 2'b11;
                end
                if (g.rvalid & sel.rready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Only the granted port sees the response bundle; the other stays all-zero.
    always_comb begin
        srsp          = '0;
        srsp[gsrc[1]] = g;
    end

    assign m.awaddr  = mreq.awaddr;
    assign m.awprot  = mreq.awprot;
    assign m.awvalid = mreq.awvalid;
    assign m.wdata   = mreq.wdata;
    assign m.wstrb   = mreq.wstrb;
    assign m.wvalid  = mreq.wvalid;
    assign m.bready  = mreq.bready;
    assign m.araddr  = mreq.araddr;
    assign m.arprot  = mreq.arprot;
    assign m.arvalid = mreq.arvalid;
    assign m.rready  = mreq.rready;

    assign s0.awready = srsp[0].awready;
    assign s0.wready  = srsp[0].wready;
    assign s0.bresp   = srsp[0].bresp;
    assign s0.bvalid  = srsp[0].bvalid;
    assign s0.arready = srsp[0].arready;
    assign s0.rdata   = srsp[0].rdata;
    assign s0.rresp   = srsp[0].rresp;
    assign s0.rvalid  = srsp[0].rvalid;

    assign s1.awready = srsp[1].awready;
    assign s1.wready  = srsp[1].wready;
    assign s1.bresp   = srsp[1].bresp;
    assign s1.bvalid  = srsp[1].bvalid;
    assign s1.arready = srsp[1].arready;
    assign s1.rdata   = srsp[1].rdata;
    assign s1.rresp   = srsp[1].rresp;
    assign s1.rvalid  = srsp[1].rvalid;

    assign busy      = (state != IDLE);
    assign grant_src = gsrc;
endmodule
